// File: rtl/tile_sequencer_if.sv
// Handshake bundle between the tile sequencer and its controller and loader/PE/storer units.
// The master modport drives requests and done pulses; the slave modport is the sequencer.
interface tile_sequencer_if #(
    parameter int AW = 8
);
    logic          start;
    logic          abort;
    logic [AW-1:0] base_a_ra;
    logic          dl_done;
    logic          wl_done;
    logic          pe_done;
    logic          st_done;

    logic          dl_start;
    logic          wl_start;
    logic          pe_start;
    logic          st_start;
    logic [2:0]    phase;
    logic          new_tile;
    logic [3:0]    tn_cnt;
    logic [1:0]    tile_cnt;
    logic [4:0]    tile_x;
    logic [4:0]    tile_y;
    logic [AW-1:0] win_base;
    logic          busy;
    logic          frame_done;

    modport master (
        output start, abort, base_a_ra, dl_done, wl_done, pe_done, st_done,
        input  dl_start, wl_start, pe_start, st_start, phase, new_tile,
               tn_cnt, tile_cnt, tile_x, tile_y, win_base, busy, frame_done
    );

    modport slave (
        input  start, abort, base_a_ra, dl_done, wl_done, pe_done, st_done,
        output dl_start, wl_start, pe_start, st_start, phase, new_tile,
               tn_cnt, tile_cnt, tile_x, tile_y, win_base, busy, frame_done
    );
endinterface

// File: rtl/tile_sequencer.sv
// Phase scheduler for the FSRCNN datapath: walks every tile of the frame through
// LOAD_D/LOAD_W/COMPUTE passes and a final STORE using start/done pulse handshakes.
module tile_sequencer #(
    parameter int AW         = 8,
    parameter int TN_ITER    = 8,
    parameter int TILE_ITER  = 4,
    parameter int GRID_W     = 18,
    parameter int GRID_H     = 18,
    parameter int ROW_STRIDE = 16
) (
    input  logic             clk,
    input  logic             rst,
    tile_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_D  = 3'd1,
        LOAD_W  = 3'd2,
        COMPUTE = 3'd3,
        STORE   = 3'd4
    } state_t;

    localparam logic [3:0] TN_LAST   = 4'(TN_ITER - 1);
    localparam logic [1:0] TILE_LAST = 2'(TILE_ITER - 1);
    localparam logic [4:0] X_LAST    = 5'(GRID_W - 1);
    localparam logic [4:0] Y_LAST    = 5'(GRID_H - 1);

    state_t      r_state;
    logic [3:0]  r_tn_cnt;
    logic [1:0]  r_tile_cnt;
    logic [4:0]  r_tile_x;
    logic [4:0]  r_tile_y;
    logic        r_dl_start;
    logic        r_wl_start;
    logic        r_pe_start;
    logic        r_st_start;
    logic        r_frame_done;

    state_t      w_next_state;
    logic [3:0]  w_next_tn_cnt;
    logic [1:0]  w_next_tile_cnt;
    logic [4:0]  w_next_tile_x;
    logic [4:0]  w_next_tile_y;
    logic        w_next_dl_start;
    logic        w_next_wl_start;
    logic        w_next_pe_start;
    logic        w_next_st_start;
    logic        w_next_frame_done;

    logic [3:0]  w_win_row;
    logic [3:0]  w_win_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tn_cnt     <= '0;
            r_tile_cnt   <= '0;
            r_tile_x     <= '0;
            r_tile_y     <= '0;
            r_dl_start   <= 1'b0;
            r_wl_start   <= 1'b0;
            r_pe_start   <= 1'b0;
            r_st_start   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_tn_cnt     <= w_next_tn_cnt;
            r_tile_cnt   <= w_next_tile_cnt;
            r_tile_x     <= w_next_tile_x;
            r_tile_y     <= w_next_tile_y;
            r_dl_start   <= w_next_dl_start;
            r_wl_start   <= w_next_wl_start;
            r_pe_start   <= w_next_pe_start;
            r_st_start   <= w_next_st_start;
            r_frame_done <= w_next_frame_done;
        end
    end

    // A registered *_start being high marks the first cycle of its phase, so
    // it doubles as the "ignore done this cycle" qualifier.
    always_comb begin
        w_next_state      = r_state;
        w_next_tn_cnt     = r_tn_cnt;
        w_next_tile_cnt   = r_tile_cnt;
        w_next_tile_x     = r_tile_x;
        w_next_tile_y     = r_tile_y;
        w_next_dl_start   = 1'b0;
        w_next_wl_start   = 1'b0;
        w_next_pe_start   = 1'b0;
        w_next_st_start   = 1'b0;
        w_next_frame_done = 1'b0;

        if (r_state != IDLE && bus.abort) begin
            w_next_state    = IDLE;
            w_next_tn_cnt   = '0;
            w_next_tile_cnt = '0;
            w_next_tile_x   = '0;
            w_next_tile_y   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        w_next_state    = LOAD_D;
                        w_next_dl_start = 1'b1;
                    end
                end
                LOAD_D: begin
                    if (bus.dl_done && !r_dl_start) begin
                        w_next_state    = LOAD_W;
                        w_next_wl_start = 1'b1;
                    end
                end
                LOAD_W: begin
                    if (bus.wl_done && !r_wl_start) begin
                        w_next_state    = COMPUTE;
                        w_next_pe_start = 1'b1;
                    end
                end
                COMPUTE: begin
                    if (bus.pe_done && !r_pe_start) begin
                        if (r_tn_cnt < TN_LAST) begin
                            w_next_tn_cnt   = r_tn_cnt + 4'd1;
                            w_next_state    = LOAD_W;
                            w_next_wl_start = 1'b1;
                        end else begin
                            w_next_tn_cnt = '0;
                            if (r_tile_cnt < TILE_LAST) begin
                                w_next_tile_cnt = r_tile_cnt + 2'd1;
                                w_next_state    = LOAD_D;
                                w_next_dl_start = 1'b1;
                            end else begin
                                w_next_tile_cnt = '0;
                                w_next_state    = STORE;
                                w_next_st_start = 1'b1;
                            end
                        end
                    end
                end
                STORE: begin
                    if (bus.st_done && !r_st_start) begin
                        if (r_tile_x < X_LAST) begin
                            w_next_tile_x   = r_tile_x + 5'd1;
                            w_next_state    = LOAD_D;
                            w_next_dl_start = 1'b1;
                        end else begin
                            w_next_tile_x = '0;
                            if (r_tile_y < Y_LAST) begin
                                w_next_tile_y   = r_tile_y + 5'd1;
                                w_next_state    = LOAD_D;
                                w_next_dl_start = 1'b1;
                            end else begin
                                w_next_tile_y     = '0;
                                w_next_frame_done = 1'b1;
                                w_next_state      = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // Weight group tn maps onto a 3x3 window position (row tn/3, column tn%3).
    assign w_win_row = r_tn_cnt / 4'd3;
    assign w_win_col = r_tn_cnt % 4'd3;

    assign bus.win_base   = bus.base_a_ra + AW'(w_win_row) * AW'(ROW_STRIDE) + AW'(w_win_col);
    assign bus.new_tile   = (r_tn_cnt == 4'd0) && (r_tile_cnt == 2'd0);
    assign bus.busy       = (r_state != IDLE);
    assign bus.phase      = r_state;
    assign bus.tn_cnt     = r_tn_cnt;
    assign bus.tile_cnt   = r_tile_cnt;
    assign bus.tile_x     = r_tile_x;
    assign bus.tile_y     = r_tile_y;
    assign bus.dl_start   = r_dl_start;
    assign bus.wl_start   = r_wl_start;
    assign bus.pe_start   = r_pe_start;
    assign bus.st_start   = r_st_start;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer: a default 18x18 instance driven by hand-stepped
// handshakes and a 2x2 instance driven by an immediate-done responder.
module tb_tile_sequencer;

    logic clk;
    logic rst;

    int checkCount;
    int passCount;
    int fdDefault;
    int fdSmall;

    tile_sequencer_if #(.AW(8)) busD ();
    tile_sequencer_if #(.AW(8)) busS ();

    tile_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (busD.slave)
    );

    tile_sequencer #(.GRID_W(2), .GRID_H(2)) u_dutSmall (
        .clk (clk),
        .rst (rst),
        .bus (busS.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; frame_done is counted here so each pulse is seen exactly once.
    task automatic tick();
        @(posedge clk);
        #1;
        if (busD.frame_done) fdDefault++;
        if (busS.frame_done) fdSmall++;
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic dl,
                                 input logic wl, input logic pe, input logic sd);
        busD.start   = st;
        busD.abort   = ab;
        busD.dl_done = dl;
        busD.wl_done = wl;
        busD.pe_done = pe;
        busD.st_done = sd;
        tick();
        busD.start   = 1'b0;
        busD.abort   = 1'b0;
        busD.dl_done = 1'b0;
        busD.wl_done = 1'b0;
        busD.pe_done = 1'b0;
        busD.st_done = 1'b0;
    endtask

    task automatic doLoadD();
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
    endtask

    task automatic doGroup();
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
    endtask

    task automatic doStore();
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
    endtask

    task automatic runSmallFrame();
        logic pendDl, pendWl, pendPe, pendSt, doneSeen;
        int   dlCnt, wlCnt, peCnt, stCnt;
        pendDl = 0; pendWl = 0; pendPe = 0; pendSt = 0; doneSeen = 0;
        dlCnt = 0; wlCnt = 0; peCnt = 0; stCnt = 0;
        fdSmall = 0;
        busS.start = 1'b1;
        tick();
        busS.start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !doneSeen; cyc++) begin
            dlCnt += int'(busS.dl_start);
            wlCnt += int'(busS.wl_start);
            peCnt += int'(busS.pe_start);
            stCnt += int'(busS.st_start);
            if (busS.frame_done) doneSeen = 1'b1;
            busS.dl_done = pendDl;
            busS.wl_done = pendWl;
            busS.pe_done = pendPe;
            busS.st_done = pendSt;
            pendDl = busS.dl_start;
            pendWl = busS.wl_start;
            pendPe = busS.pe_start;
            pendSt = busS.st_start;
            tick();
        end
        busS.dl_done = 1'b0;
        busS.wl_done = 1'b0;
        busS.pe_done = 1'b0;
        busS.st_done = 1'b0;
        checkOutput("small_timeout", 32'(doneSeen), 32'd1);
        checkOutput("small_dl_start_count", 32'(dlCnt), 32'd16);
        checkOutput("small_wl_start_count", 32'(wlCnt), 32'd128);
        checkOutput("small_pe_start_count", 32'(peCnt), 32'd128);
        checkOutput("small_st_start_count", 32'(stCnt), 32'd4);
        checkOutput("small_frame_done_count", 32'(fdSmall), 32'd1);
        checkOutput("small_end_phase", 32'(busS.phase), 32'd0);
        checkOutput("small_end_tile_y", 32'(busS.tile_y), 32'd0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        fdDefault  = 0;
        fdSmall    = 0;
        rst = 1'b1;
        busD.start = 0; busD.abort = 0; busD.base_a_ra = 8'hF8;
        busD.dl_done = 0; busD.wl_done = 0; busD.pe_done = 0; busD.st_done = 0;
        busS.start = 0; busS.abort = 0; busS.base_a_ra = 8'h00;
        busS.dl_done = 0; busS.wl_done = 0; busS.pe_done = 0; busS.st_done = 0;
        tick();
        tick();
        rst = 1'b0;

        checkOutput("reset_phase", 32'(busD.phase), 32'd0);
        checkOutput("reset_busy", 32'(busD.busy), 32'd0);
        checkOutput("reset_starts", 32'({busD.dl_start, busD.wl_start, busD.pe_start, busD.st_start}), 32'd0);
        checkOutput("reset_frame_done", 32'(busD.frame_done), 32'd0);
        checkOutput("reset_counters", 32'({busD.tn_cnt, busD.tile_cnt, busD.tile_x, busD.tile_y}), 32'd0);

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("start_phase", 32'(busD.phase), 32'd1);
        checkOutput("start_dl_start", 32'(busD.dl_start), 32'd1);
        checkOutput("start_busy", 32'(busD.busy), 32'd1);
        checkOutput("win_base_tn0", 32'(busD.win_base), 32'hF8);
        checkOutput("new_tile_tn0", 32'(busD.new_tile), 32'd1);

        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("dl_done_in_start_cycle", 32'(busD.phase), 32'd1);
        checkOutput("dl_start_pulse_width", 32'(busD.dl_start), 32'd0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("load_w_phase", 32'(busD.phase), 32'd2);
        checkOutput("load_w_wl_start", 32'(busD.wl_start), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("pe_done_in_load_w_phase", 32'(busD.phase), 32'd2);
        checkOutput("pe_done_in_load_w_tn", 32'(busD.tn_cnt), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("compute_pe_start", 32'(busD.pe_start), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("dl_done_in_compute_phase", 32'(busD.phase), 32'd3);
        checkOutput("dl_done_in_compute_tn", 32'(busD.tn_cnt), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("group1_phase", 32'(busD.phase), 32'd2);
        checkOutput("group1_tn", 32'(busD.tn_cnt), 32'd1);
        checkOutput("win_base_tn1", 32'(busD.win_base), 32'hF9);

        for (int g = 0; g < 3; g++) doGroup();
        checkOutput("win_base_tn4", 32'(busD.win_base), 32'h09);
        for (int g = 0; g < 3; g++) doGroup();
        checkOutput("tn7", 32'(busD.tn_cnt), 32'd7);
        checkOutput("win_base_tn7_wrap", 32'(busD.win_base), 32'h19);
        doGroup();
        checkOutput("pass1_phase", 32'(busD.phase), 32'd1);
        checkOutput("pass1_tile_cnt", 32'(busD.tile_cnt), 32'd1);
        checkOutput("pass1_dl_start", 32'(busD.dl_start), 32'd1);
        checkOutput("pass1_new_tile", 32'(busD.new_tile), 32'd0);

        doLoadD();
        for (int g = 0; g < 8; g++) doGroup();
        doLoadD();
        for (int g = 0; g < 5; g++) doGroup();
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("pre_abort_state", 32'({busD.phase, busD.tn_cnt, busD.tile_cnt}), 32'({3'd3, 4'd5, 2'd2}));
        applyStimulus(0, 1, 0, 0, 1, 0);
        checkOutput("abort_phase", 32'(busD.phase), 32'd0);
        checkOutput("abort_counters", 32'({busD.tn_cnt, busD.tile_cnt, busD.tile_x, busD.tile_y}), 32'd0);
        checkOutput("abort_no_start", 32'({busD.dl_start, busD.wl_start, busD.pe_start, busD.st_start}), 32'd0);
        checkOutput("abort_no_frame_done", 32'(busD.frame_done), 32'd0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("start_with_abort_idle", 32'(busD.phase), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("restart_phase", 32'(busD.phase), 32'd1);
        checkOutput("restart_tile_xy", 32'({busD.tile_x, busD.tile_y}), 32'd0);

        fdDefault = 0;
        for (int t = 0; t < 324; t++) begin
            for (int p = 0; p < 4; p++) begin
                doLoadD();
                for (int g = 0; g < 8; g++) doGroup();
            end
            if (t == 323) begin
                checkOutput("last_tile_store_phase", 32'(busD.phase), 32'd4);
                checkOutput("last_tile_xy", 32'({busD.tile_x, busD.tile_y}), 32'({5'd17, 5'd17}));
            end
            doStore();
            if (t == 0) begin
                checkOutput("tile0_next_xy", 32'({busD.tile_x, busD.tile_y}), 32'({5'd1, 5'd0}));
                checkOutput("tile0_next_dl_start", 32'(busD.dl_start), 32'd1);
            end
            if (t == 17) begin
                checkOutput("row_wrap_xy", 32'({busD.tile_x, busD.tile_y}), 32'({5'd0, 5'd1}));
            end
        end
        checkOutput("frame_end_frame_done", 32'(busD.frame_done), 32'd1);
        checkOutput("frame_end_phase", 32'(busD.phase), 32'd0);
        checkOutput("frame_end_xy", 32'({busD.tile_x, busD.tile_y}), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("frame_done_pulse_width", 32'(busD.frame_done), 32'd0);
        checkOutput("frame_done_count", 32'(fdDefault), 32'd1);

        runSmallFrame();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
